// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-type encoding, address map and helpers.
package lsu_pkg;

  localparam int unsigned DMEM_WORDS_DEFAULT = 2048;

  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LBU = 4'b0001,
    OP_LH  = 4'b0010,
    OP_LHU = 4'b0011,
    OP_LW  = 4'b0100,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } lsu_op_e;

  localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
  localparam logic [31:0] DMEM_LIMIT = 32'h0000_3FFF;
  localparam logic [31:0] LEDR_ADDR  = 32'h0000_7000;
  localparam logic [31:0] LEDG_ADDR  = 32'h0000_7010;
  localparam logic [31:0] HEX_ADDR   = 32'h0000_7020;
  localparam logic [31:0] SW_ADDR    = 32'h0000_7800;

  // Replace the byte lanes of old_w selected by be with those of new_w.
  function automatic logic [31:0] byte_merge(logic [31:0] old_w,
                                             logic [31:0] new_w,
                                             logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath-to-LSU bus: address, store data, op, switch inputs and results.
interface lsu_if;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic [3:0]  i_lsu_op;
  logic [31:0] i_io_sw;
  logic [31:0] o_ld_data;
  logic [31:0] o_io_ledr;
  logic [31:0] o_io_ledg;
  logic [31:0] o_io_hex;
  logic        o_misaligned;

  modport master (
    output i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_op, i_io_sw,
    input  o_ld_data, o_io_ledr, o_io_ledg, o_io_hex, o_misaligned
  );

  modport slave (
    input  i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_op, i_io_sw,
    output o_ld_data, o_io_ledr, o_io_ledg, o_io_hex, o_misaligned
  );
endinterface

// File: rtl/lsu_dmem.sv
// Byte-enabled data memory: asynchronous read, synchronous write, no reset.
module dmem
  import lsu_pkg::*;
#(
  parameter int unsigned WORDS = DMEM_WORDS_DEFAULT,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  // Write only the enabled lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= byte_merge(mem[idx], wdata, be);
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/lsu_top.sv
// Load/store unit: address decode, lane steering, load extension,
// memory-mapped LED/HEX registers and switch synchronizer.
module lsu_top
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
  input  logic  i_clk,
  input  logic  i_reset,
  lsu_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DMEM_WORDS);

  logic [31:0] addr;
  logic [3:0]  op;
  logic        legal, align_err, bad, is_load;
  logic        in_dmem, hit_ledr, hit_ledg, hit_hex, hit_sw;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        commit;
  logic [31:0] dmem_rdata, rd_word, ld_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ledr_q, ledg_q, hex_q;
  logic [31:0] sw_meta, sw_sync;

  assign addr = bus.i_lsu_addr;
  assign op   = bus.i_lsu_op;

  // Classify the op and detect misalignment / illegal combinations.
  always_comb begin
    legal     = 1'b1;
    align_err = 1'b0;
    is_load   = 1'b0;
    case (op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load   = 1'b1;
        align_err = addr[0];
      end
      OP_LW: begin
        is_load   = 1'b1;
        align_err = (addr[1:0] != 2'b00);
      end
      OP_SB: ;
      OP_SH: align_err = addr[0];
      OP_SW: align_err = (addr[1:0] != 2'b00);
      default: legal = 1'b0;
    endcase
    bad = ~legal | align_err | (bus.i_lsu_wren & ~op[3]);
  end

  // Region decode; IO registers match on the word address.
  always_comb begin
    in_dmem  = (addr >= DMEM_BASE) && (addr <= DMEM_LIMIT);
    hit_ledr = (addr[31:2] == LEDR_ADDR[31:2]);
    hit_ledg = (addr[31:2] == LEDG_ADDR[31:2]);
    hit_hex  = (addr[31:2] == HEX_ADDR[31:2]);
    hit_sw   = (addr[31:2] == SW_ADDR[31:2]);
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = '0;
    wdata = '0;
    case (op)
      OP_SB: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{bus.i_st_data[7:0]}};
      end
      OP_SH: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.i_st_data[15:0]}};
      end
      OP_SW: begin
        be    = '1;
        wdata = bus.i_st_data;
      end
      default: ;
    endcase
  end

  // Gating on i_reset keeps DMEM (which has no reset) from taking a write
  // while reset is held.
  assign commit = bus.i_lsu_wren & op[3] & ~bad & ~i_reset;

  dmem #(
    .WORDS (DMEM_WORDS),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk   (i_clk),
    .we    (commit & in_dmem),
    .be    (be),
    .idx   (addr[IDX_W+1:2]),
    .wdata (wdata),
    .rdata (dmem_rdata)
  );

  // LED and HEX registers, byte-lane writable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hex_q  <= '0;
    end else if (commit) begin
      if (hit_ledr) ledr_q <= byte_merge(ledr_q, wdata, be);
      if (hit_ledg) ledg_q <= byte_merge(ledg_q, wdata, be);
      if (hit_hex)  hex_q  <= byte_merge(hex_q,  wdata, be);
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.i_io_sw;
      sw_sync <= sw_meta;
    end
  end

  // Read source select, then lane extraction and extension.
  always_comb begin
    rd_word = '0;
    if (in_dmem)       rd_word = dmem_rdata;
    else if (hit_ledr) rd_word = ledr_q;
    else if (hit_ledg) rd_word = ledg_q;
    else if (hit_hex)  rd_word = hex_q;
    else if (hit_sw)   rd_word = sw_sync;
    rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = '0;
    if (is_load && !bad) begin
      case (op)
        OP_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
        OP_LBU:  ld_data = {24'h0, rd_byte};
        OP_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
        OP_LHU:  ld_data = {16'h0, rd_half};
        OP_LW:   ld_data = rd_word;
        default: ld_data = '0;
      endcase
    end
  end

  assign bus.o_ld_data    = ld_data;
  assign bus.o_misaligned = bad;
  assign bus.o_io_ledr    = ledr_q;
  assign bus.o_io_ledg    = ledg_q;
  assign bus.o_io_hex     = hex_q;

endmodule

// File: tb/tb_lsu_top.sv
// Directed vector bench for lsu_top.
module tb_lsu_top;
  import lsu_pkg::*;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b0;

  lsu_if bus ();

  lsu_top #(
    .DMEM_WORDS (2048)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        wren;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] exp_ld;
    logic        exp_mis;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] o, input logic [31:0] a, input logic [31:0] s);
    bus.i_lsu_wren = w;
    bus.i_lsu_op   = o;
    bus.i_lsu_addr = a;
    bus.i_st_data  = s;
  endtask

  function automatic void add(input string n, input logic w, input logic [3:0] o,
                              input logic [31:0] a, input logic [31:0] s,
                              input logic [31:0] e, input logic m);
    vec_t v;
    v.name = n; v.wren = w; v.op = o; v.addr = a; v.st = s; v.exp_ld = e; v.exp_mis = m;
    vq.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // name, wren, op, addr, store data, expected load, expected misaligned
    add("sw_2000",   1, OP_SW,  32'h2000, 32'h8765_4321, 32'h0, 0);
    add("lb_2000",   0, OP_LB,  32'h2000, 32'h0, 32'h0000_0021, 0);
    add("lbu_2000",  0, OP_LBU, 32'h2000, 32'h0, 32'h0000_0021, 0);
    add("lh_2000",   0, OP_LH,  32'h2000, 32'h0, 32'h0000_4321, 0);
    add("lhu_2000",  0, OP_LHU, 32'h2000, 32'h0, 32'h0000_4321, 0);
    add("lw_2000",   0, OP_LW,  32'h2000, 32'h0, 32'h8765_4321, 0);
    add("lb_2003",   0, OP_LB,  32'h2003, 32'h0, 32'hFFFF_FF87, 0);
    add("lbu_2003",  0, OP_LBU, 32'h2003, 32'h0, 32'h0000_0087, 0);
    add("lh_2002",   0, OP_LH,  32'h2002, 32'h0, 32'hFFFF_8765, 0);
    add("sw0_2004",  1, OP_SW,  32'h2004, 32'h0, 32'h0, 0);
    add("sb_2006",   1, OP_SB,  32'h2006, 32'h1234_56AB, 32'h0, 0);
    add("sh_2004",   1, OP_SH,  32'h2004, 32'hCAFE_BEEF, 32'h0, 0);
    add("lw_2004",   0, OP_LW,  32'h2004, 32'h0, 32'h00AB_BEEF, 0);
    add("sh_mis",    1, OP_SH,  32'h2001, 32'hFFFF_FFFF, 32'h0, 1);
    add("sw_mis",    1, OP_SW,  32'h2002, 32'hFFFF_FFFF, 32'h0, 1);
    add("lw_keep0",  0, OP_LW,  32'h2000, 32'h0, 32'h8765_4321, 0);
    add("lw_keep4",  0, OP_LW,  32'h2004, 32'h0, 32'h00AB_BEEF, 0);
    add("lh_mis",    0, OP_LH,  32'h2001, 32'h0, 32'h0, 1);
    add("lw_mis",    0, OP_LW,  32'h2002, 32'h0, 32'h0, 1);
    add("wren_load", 1, OP_LW,  32'h2000, 32'h0, 32'h0, 1);
    add("bad_op",    0, 4'b0101, 32'h2000, 32'h0, 32'h0, 1);
    add("sw_4000",   1, OP_SW,  32'h4000, 32'h1234_5678, 32'h0, 0);
    add("lw_4000",   0, OP_LW,  32'h4000, 32'h0, 32'h0, 0);
    add("lw_after4k",0, OP_LW,  32'h2000, 32'h0, 32'h8765_4321, 0);
    add("sw_3ffc",   1, OP_SW,  32'h3FFC, 32'h1111_2222, 32'h0, 0);
    add("sw_1ffc",   1, OP_SW,  32'h1FFC, 32'hDEAD_BEEF, 32'h0, 0);
    add("sw_6000",   1, OP_SW,  32'h6000, 32'hCAFE_F00D, 32'h0, 0);
    add("lw_3ffc",   0, OP_LW,  32'h3FFC, 32'h0, 32'h1111_2222, 0);
    add("lw_noalias",0, OP_LW,  32'h2000, 32'h0, 32'h8765_4321, 0);
    add("lw_1ffc",   0, OP_LW,  32'h1FFC, 32'h0, 32'h0, 0);
    add("sw_ledr",   1, OP_SW,  32'h7000, 32'h0000_00FF, 32'h0, 0);
    add("lw_ledr",   0, OP_LW,  32'h7000, 32'h0, 32'h0000_00FF, 0);
    add("sb_ledg",   1, OP_SB,  32'h7011, 32'hFFFF_FF5A, 32'h0, 0);
    add("lb_ledg",   0, OP_LB,  32'h7011, 32'h0, 32'h0000_005A, 0);
    add("lhu_ledg",  0, OP_LHU, 32'h7010, 32'h0, 32'h0000_5A00, 0);
    add("sh_hex",    1, OP_SH,  32'h7022, 32'h7777_8001, 32'h0, 0);
    add("lh_hex",    0, OP_LH,  32'h7022, 32'h0, 32'hFFFF_8001, 0);
    add("lbu_hex",   0, OP_LBU, 32'h7023, 32'h0, 32'h0000_0080, 0);
    add("lw_7004",   0, OP_LW,  32'h7004, 32'h0, 32'h0, 0);

    // Reset: IO registers and synchronizer cleared asynchronously.
    bus.i_io_sw = '0;
    drive(0, OP_LW, 32'h7800, 32'h0);
    #1 i_reset = 1'b1;
    #1;
    check("rst_ledr", bus.o_io_ledr, 32'h0);
    check("rst_ledg", bus.o_io_ledg, 32'h0);
    check("rst_hex",  bus.o_io_hex,  32'h0);
    check("rst_sw",   bus.o_ld_data, 32'h0);
    repeat (2) @(posedge i_clk);
    #2 i_reset = 1'b0;

    foreach (vq[i]) begin
      @(posedge i_clk);
      #1 drive(vq[i].wren, vq[i].op, vq[i].addr, vq[i].st);
      #2;
      check({vq[i].name, "_ld"},  bus.o_ld_data, vq[i].exp_ld);
      check({vq[i].name, "_mis"}, {31'h0, bus.o_misaligned}, {31'h0, vq[i].exp_mis});
    end

    check("ledr_reg", bus.o_io_ledr, 32'h0000_00FF);
    check("ledg_reg", bus.o_io_ledg, 32'h0000_5A00);
    check("hex_reg",  bus.o_io_hex,  32'h8001_0000);

    // Switch synchronizer: new value visible only after the second edge.
    @(posedge i_clk);
    #1 bus.i_io_sw = 32'h0000_0005;
    drive(0, OP_LW, 32'h7800, 32'h0);
    #2 check("sw_pre", bus.o_ld_data, 32'h0);
    @(posedge i_clk);
    #1 check("sw_edge1", bus.o_ld_data, 32'h0);
    @(posedge i_clk);
    #1 check("sw_edge2", bus.o_ld_data, 32'h0000_0005);
    drive(1, OP_SW, 32'h7800, 32'hFFFF_FFFF);
    @(posedge i_clk);
    #1 drive(0, OP_LW, 32'h7800, 32'h0);
    #1 check("sw_ro", bus.o_ld_data, 32'h0000_0005);

    // Mid-cycle reset: IO cleared at once, pending store blocked, DMEM kept.
    @(posedge i_clk);
    #1 drive(1, OP_SW, 32'h2000, 32'h0000_0055);
    #2 i_reset = 1'b1;
    #1;
    check("mrst_ledr", bus.o_io_ledr, 32'h0);
    check("mrst_ledg", bus.o_io_ledg, 32'h0);
    check("mrst_hex",  bus.o_io_hex,  32'h0);
    @(posedge i_clk);
    #1 drive(0, OP_LW, 32'h2000, 32'h0);
    #1 check("mrst_dmem", bus.o_ld_data, 32'h8765_4321);
    drive(0, OP_LW, 32'h7800, 32'h0);
    #1 check("mrst_sw", bus.o_ld_data, 32'h0);

    // First edge after deassertion commits a store.
    @(posedge i_clk);
    #1 drive(1, OP_SW, 32'h7000, 32'h0000_00AA);
    #2 i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    check("post_rst_ledr", bus.o_io_ledr, 32'h0000_00AA);
    check("post_rst_ledg", bus.o_io_ledg, 32'h0);
    drive(0, OP_LW, 32'h2000, 32'h0);
    #1 check("post_rst_dmem", bus.o_ld_data, 32'h8765_4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_top.md
LSU_TOP -- requirements
Module: lsu_top

Interface
REQ-001 Parameter DMEM_WORDS, default 2048, SHALL set the data memory depth in 32-bit words (8 KiB).
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 i_lsu_addr  input  32  SHALL be the byte address (ALU result).
REQ-005 i_st_data  input  32  SHALL be the store data (rs2); the low byte/halfword is used for SB/SH.
REQ-006 i_lsu_wren  input  1  SHALL be the store enable from the control unit (mem_wren).
REQ-007 i_lsu_op  input  4  SHALL be the access type: 0000 LB, 0001 LBU, 0010 LH, 0011 LHU, 0100 LW, 1000 SB, 1001 SH, 1010 SW; other codes are illegal.
REQ-008 i_io_sw  input  32  SHALL be the raw, asynchronous switch inputs.
REQ-009 o_ld_data  output  32  SHALL be the extended load result (wb_sel=01 path).
REQ-010 o_io_ledr  output  32  SHALL be the red LED register.
REQ-011 o_io_ledg  output  32  SHALL be the green LED register.
REQ-012 o_io_hex  output  32  SHALL be the seven-segment register (4 x 8-bit digits).
REQ-013 o_misaligned  output  1  SHALL flag the current access as misaligned or illegal.

Function
REQ-014 Address map SHALL be:
- DMEM 0x0000_2000-0x0000_3FFF
- LEDR 0x0000_7000
- LEDG 0x0000_7010
- HEX 0x0000_7020
- SW 0x0000_7800 (read-only)
- Any other address is unmapped.
REQ-015 Loads SHALL be combinational: o_ld_data valid in the same cycle as address and op (zero-latency read), as the single-cycle datapath requires.
REQ-016 Stores SHALL commit on the rising edge where i_lsu_wren=1 and i_lsu_op[3]=1; only the addressed byte lanes SHALL change.
REQ-017 Byte lanes SHALL be:
- SB: lane addr[1:0] gets st[7:0].
- SH: lanes {addr[1],0} and {addr[1],1} get st[15:0].
- SW: all four lanes.
REQ-018 Load extension SHALL be:
- LB/LH: sign-extend the selected byte/halfword.
- LBU/LHU: zero-extend it.
- LW: full word.
REQ-019 Misalignment SHALL be: halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-020 When misaligned or illegal, o_misaligned=1, stores SHALL be suppressed, and o_ld_data SHALL be 0.
REQ-021 Stores to unmapped addresses or SW SHALL be ignored; loads from unmapped addresses SHALL return 0.
REQ-022 IO registers SHALL be readable; a load from an LED/HEX address returns the current register contents, extended per op.
REQ-023 i_io_sw SHALL pass through a 2-flop synchronizer; SW loads return the second-stage value, so a switch change is visible 2 edges later.
REQ-024 A store followed by a load of the same address SHALL return the new data in the next cycle; a same-cycle load SHALL return the old data.
REQ-025 i_lsu_wren=1 with i_lsu_op[3]=0 SHALL be treated as illegal: no write, o_misaligned=1.
REQ-026 DMEM index SHALL be addr[12:2]; addresses outside the DMEM window SHALL never alias into it.

Reset
REQ-027 While i_reset=1:
- o_io_ledr, o_io_ledg, o_io_hex and both synchronizer stages SHALL be 0 immediately (asynchronously).
- Stores SHALL be blocked.
REQ-028 DMEM contents SHALL be unaffected by reset.
REQ-029 A store coinciding with the reset assertion edge SHALL NOT commit.
REQ-030 The first store commit after reset SHALL occur on the first rising edge after deassertion.

Structure
REQ-031 Shared package lsu_pkg SHALL hold:
- the lsu_op enum (values per REQ-007);
- address-map base/limit constants;
- the DMEM_WORDS default.
The control unit SHALL use the same enum.
REQ-032 One sub-module, dmem, SHALL implement the byte-enabled memory: async read, sync write, 4-bit byte enable.
REQ-033 lsu_top SHALL contain the address decode, lane/extension logic, IO registers and synchronizer.

Verification
REQ-034 SW 0x8765_4321 to 0x2000, then LB/LBU/LH/LHU/LW at 0x2000 -> 0x0000_0021, 0x0000_0021, 0x0000_4321, 0x0000_4321, 0x8765_4321; LB at 0x2003 -> 0xFFFF_FF87.
REQ-035 SW 0 to 0x2004, SB 0xAB to 0x2006, SH 0xBEEF to 0x2004 -> LW at 0x2004 returns 0x00AB_BEEF.
REQ-036 SH to 0x2001 and SW to 0x2002 -> o_misaligned=1 in that cycle, memory unchanged, o_ld_data=0.
REQ-037 SW 0x0000_00FF to 0x7000 -> o_io_ledr=0x0000_00FF after the edge; LW at 0x7000 returns 0xFF; assert i_reset mid-cycle -> o_io_ledr=0 at once; DMEM word at 0x2000 retained.
REQ-038 i_io_sw goes 0 to 0x0000_0005 -> LW at 0x7800 returns 0 for 1 edge, then 0x5 after the 2nd edge; SW to 0x7800 ignored.
REQ-039 SW 0x1234_5678 to 0x4000 (unmapped) -> no state change; LW at 0x4000 returns 0; LW at 0x2000 still returns its previous value.
